universal_shift_reg: RTL and testbench
======================================

Name: universal_shift_reg

Overview:
- Parametrised universal shift/rotate register; the next generation of the lab's 8-bit rotate register.
- Adds parallel load, clear, rotate left/right, logical shift left/right, and arithmetic shift right.
- Multi-bit shifts run through a start/busy/done handshake: one bit position per clock, counted by an internal FSM.
- Sits between switch/key inputs or a controller FSM and the LEDR/HEX display path.

Parameters:
- WIDTH, 8, register width in bits (≥2).
- AW, 4, width of the shift-amount port; max amount = 2^AW − 1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- start  in  1  request; sampled only in IDLE.
- op  in  3  operation code, captured with start.
- amount  in  AW  number of single-bit steps, captured with start.
- Data_IN  in  WIDTH  parallel load data.
- serial_in  in  1  fill bit for LSR/LSL, sampled live on each shift edge.
- Q  out  WIDTH  register contents.
- busy  out  1  multi-cycle operation in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (asynchronous, active-low, independent of clock):
  - Q=0, busy=0, done=0, FSM=IDLE, count=0.
  - Applies immediately, including mid-operation. The aborted operation never produces done.
- Op codes:
  - 000 LOAD: Q<=Data_IN.
  - 001 ROR: Q<={Q[0],Q[W-1:1]}.
  - 010 ROL: Q<={Q[W-2:0],Q[W-1]}.
  - 011 LSR: Q<={serial_in,Q[W-1:1]}.
  - 100 LSL: Q<={Q[W-2:0],serial_in}.
  - 101 ASR: Q<={Q[W-1],Q[W-1:1]}.
  - 110 CLEAR: Q<=0.
  - 111 NOP: Q unchanged.
- FSM states: IDLE, SHIFT.
- IDLE, start=1 at edge E0:
  - LOAD/CLEAR/NOP: Q updated at E0. done=1 for the cycle after E0. busy stays 0. FSM stays in IDLE.
  - Shift/rotate ops: op and amount latched; count<=amount; busy<=1; go to SHIFT. Q unchanged at E0.
- SHIFT, each edge:
  - count≠0: perform the latched op by one bit; count<=count−1.
  - count=0: busy<=0, done<=1, go to IDLE. No shift on this edge.
- Latency: amount=N shifts on edges E1..EN; done asserted at E(N+1). busy is high from E0 to E(N+1).
- amount=0: done at E1, Q unchanged.
- Amounts ≥ WIDTH are not clamped; each step is applied literally.
  - Rotate by WIDTH returns the original value.
  - LSR/LSL by ≥ WIDTH yields all serial_in bits.
- start while busy=1 is ignored. Changes to op/amount while busy=1 have no effect.
- done is a single-cycle pulse and is never held. It may be followed by a new start accepted on the very next edge.
- Back-to-back LOAD/CLEAR with start held high: one operation per clock, done high each cycle.

Optional Feature:
- Macro USR_CARRY_EN.
- When defined:
  - Adds output port carry (1 bit).
  - Each shift step captures the bit leaving the register: Q[0] for ROR/LSR/ASR, Q[W-1] for ROL/LSL.
  - carry=0 on reset, LOAD, and CLEAR. Unchanged on NOP and on amount=0.
- When undefined: no carry port and no carry logic; all other behaviour is identical.

Test Plan (WIDTH=8, AW=4):
- Drive reset=0 asynchronously mid-cycle while Q=8'hFF and busy=1 → Q=8'h00, busy=0, done=0 before the next clock edge; no done afterwards.
- start, op=000, Data_IN=8'hB4 → Q=8'hB4 after E0; done high exactly one cycle; busy never high.
- From Q=8'hB4: start, op=001, amount=3 → Q=8'h96 at E3; done at E4; busy high for 4 cycles.
- From Q=8'h96: ASR amount=2 gives Q=8'hE5. Then LSL amount=4 with serial_in=1 gives Q=8'h5F, carry=0 (with USR_CARRY_EN).
- Pulse start with op=011 while busy=1 → ignored, Q sequence unchanged. Then amount=0 → done at E1, Q unchanged.
- ROL amount=8 from 8'h3C → Q=8'h3C, done at E9. ROL amount=10, reset at E5 → Q=0, done never asserted.

Source files
------------

// File: rtl/universal_shift_reg.sv
// universal_shift_reg
// Parametrised universal shift/rotate register with parallel load and clear.
// Multi-bit shifts use a start/busy/done handshake and advance one bit
// position per clock, counted down by a two-state FSM (IDLE, SHIFT).
// Optional feature: define USR_CARRY_EN to add a 'carry' output that holds
// the last bit shifted or rotated out of the register.
module universal_shift_reg #(
   parameter int WIDTH = 8,
   parameter int AW    = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [AW-1:0]    amount,
   input  logic [WIDTH-1:0] Data_IN,
   input  logic             serial_in,
   output logic [WIDTH-1:0] Q,
   output logic             busy,
   output logic             done
`ifdef USR_CARRY_EN
   ,
   output logic             carry
`endif
);

   localparam logic [2:0] OP_LOAD  = 3'b000;
   localparam logic [2:0] OP_ROR   = 3'b001;
   localparam logic [2:0] OP_ROL   = 3'b010;
   localparam logic [2:0] OP_LSR   = 3'b011;
   localparam logic [2:0] OP_LSL   = 3'b100;
   localparam logic [2:0] OP_ASR   = 3'b101;
   localparam logic [2:0] OP_CLEAR = 3'b110;
   localparam logic [2:0] OP_NOP   = 3'b111;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [AW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] q_d;
   logic             busy_d;
   logic             done_d;
`ifdef USR_CARRY_EN
   logic             carry_d;
`endif

   // One single-bit step of a shift/rotate op; serial_in feeds LSR/LSL only.
   function automatic logic [WIDTH-1:0] shift_step(input logic [2:0]       o,
                                                   input logic [WIDTH-1:0] q,
                                                   input logic             sin);
      logic signed [WIDTH-1:0] qs;
      qs = q;
      case (o)
         OP_ROR:  shift_step = {q[0], q[WIDTH-1:1]};
         OP_ROL:  shift_step = {q[WIDTH-2:0], q[WIDTH-1]};
         OP_LSR:  shift_step = {sin, q[WIDTH-1:1]};
         OP_LSL:  shift_step = {q[WIDTH-2:0], sin};
         OP_ASR:  shift_step = qs >>> 1;
         default: shift_step = q;
      endcase
   endfunction

`ifdef USR_CARRY_EN
   // Bit that leaves the register on one step: MSB for left moves, LSB otherwise.
   function automatic logic carry_out(input logic [2:0]       o,
                                      input logic [WIDTH-1:0] q);
      if (o == OP_ROL || o == OP_LSL)
         carry_out = q[WIDTH-1];
      else
         carry_out = q[0];
   endfunction
`endif

   // Next-state, next-register and handshake decode.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      count_d = count_q;
      q_d     = Q;
      busy_d  = busy;
      done_d  = 1'b0;
`ifdef USR_CARRY_EN
      carry_d = carry;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               case (op)
                  OP_LOAD: begin
                     q_d    = Data_IN;
                     done_d = 1'b1;
`ifdef USR_CARRY_EN
                     carry_d = 1'b0;
`endif
                  end
                  OP_CLEAR: begin
                     q_d    = '0;
                     done_d = 1'b1;
`ifdef USR_CARRY_EN
                     carry_d = 1'b0;
`endif
                  end
                  OP_NOP: begin
                     done_d = 1'b1;
                  end
                  default: begin
                     // Latch the request; the register moves only from the next edge on.
                     op_d    = op;
                     count_d = amount;
                     busy_d  = 1'b1;
                     state_d = SHIFT;
                  end
               endcase
            end
         end
         SHIFT: begin
            if (count_q != '0) begin
               q_d     = shift_step(op_q, Q, serial_in);
               count_d = count_q - AW'(1);
`ifdef USR_CARRY_EN
               carry_d = carry_out(op_q, Q);
`endif
            end else begin
               // Count exhausted: this edge only finishes the handshake.
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State, register and handshake flops; reset aborts any operation at once.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         op_q    <= OP_LOAD;
         count_q <= '0;
         Q       <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
`ifdef USR_CARRY_EN
         carry   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         count_q <= count_d;
         Q       <= q_d;
         busy    <= busy_d;
         done    <= done_d;
`ifdef USR_CARRY_EN
         carry   <= carry_d;
`endif
      end
   end

endmodule

// File: tb/tb_universal_shift_reg.sv
// tb_universal_shift_reg
// Scoreboard bench for universal_shift_reg (WIDTH=8, AW=4). Expected register
// contents are computed from a behavioural model when each request is driven
// and compared when the DUT signals done.
module tb_universal_shift_reg;

   logic       clock;
   logic       reset;
   logic       start;
   logic [2:0] op;
   logic [3:0] amount;
   logic [7:0] Data_IN;
   logic       serial_in;
   logic [7:0] Q;
   logic       busy;
   logic       done;
`ifdef USR_CARRY_EN
   logic       carry;
`endif

   int checks   = 0;
   int failures = 0;

   logic [8:0] sb_q[$];    // {carry, Q} expectations
   logic [7:0] model_q = 8'h00;
   logic       model_c = 1'b0;

   universal_shift_reg #(.WIDTH(8), .AW(4)) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .amount    (amount),
      .Data_IN   (Data_IN),
      .serial_in (serial_in),
      .Q         (Q),
      .busy      (busy),
      .done      (done)
`ifdef USR_CARRY_EN
      ,
      .carry     (carry)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Single comparison point for the whole bench.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Behavioural model: returns {carry, Q} after the whole operation.
   function automatic logic [8:0] model(input logic [2:0] o, input logic [3:0] n,
                                        input logic [7:0] q, input logic c,
                                        input logic [7:0] d, input logic sin);
      case (o)
         3'd0: return {1'b0, d};
         3'd6: return 9'h000;
         3'd7: return {c, q};
         default: begin
            for (int i = 0; i < int'(n); i++) begin
               case (o)
                  3'd1: begin c = q[0]; q = (q >> 1) | (q << 7); end
                  3'd2: begin c = q[7]; q = (q << 1) | (q >> 7); end
                  3'd3: begin c = q[0]; q = (q >> 1) | {sin, 7'b0}; end
                  3'd4: begin c = q[7]; q = (q << 1) | {7'b0, sin}; end
                  default: begin c = q[0]; q = (q >> 1) | (q & 8'h80); end
               endcase
            end
            return {c, q};
         end
      endcase
   endfunction

   // Present a request and let it be captured at edge E0.
   task automatic start_op(input logic [2:0] o, input logic [3:0] n,
                           input logic [7:0] d, input logic sin);
      @(negedge clock);
      start = 1'b1; op = o; amount = n; Data_IN = d; serial_in = sin;
      @(posedge clock);
      #1 start = 1'b0;
   endtask

   // Full transaction: drive, wait for done (bounded), check latency, busy, result.
   task automatic run_op(input logic [2:0] o, input logic [3:0] n, input logic [7:0] d,
                         input logic sin, input logic interfere, input string tag);
      logic [8:0] exp;
      logic       short_op;
      int         cyc;
      int         busy_cnt;
      int         exp_lat;
      exp = model(o, n, model_q, model_c, d, sin);
      sb_q.push_back(exp);
      short_op = (o == 3'd0) || (o == 3'd6) || (o == 3'd7);
      exp_lat  = short_op ? 0 : int'(n) + 1;
      start_op(o, n, d, sin);
      cyc = 0;
      busy_cnt = 0;
      while (!done && cyc < 40) begin
         if (busy) busy_cnt++;
         if (interfere && cyc == 1) begin
            start = 1'b1; op = 3'd3; amount = 4'd1; serial_in = ~serial_in;
         end
         if (interfere && cyc == 2) start = 1'b0;
         @(posedge clock);
         #1;
         cyc++;
      end
      check({tag, "_lat"}, cyc, exp_lat);
      check({tag, "_busy"}, busy_cnt, exp_lat);
      exp = sb_q.pop_front();
      check({tag, "_q"}, {24'h0, Q}, {24'h0, exp[7:0]});
`ifdef USR_CARRY_EN
      check({tag, "_carry"}, {31'h0, carry}, {31'h0, exp[8]});
`endif
      model_q = exp[7:0];
      model_c = exp[8];
      @(posedge clock);
      #1 check({tag, "_pulse"}, {31'h0, done}, 32'h0);
   endtask

   initial begin
      logic [2:0] bops [3];
      logic [7:0] bdat [3];
      logic [8:0] exp;
      int         done_seen;

      reset = 1'b0; start = 1'b0; op = 3'd0; amount = 4'd0;
      Data_IN = 8'h00; serial_in = 1'b0;
      #12;
      check("rst_q", {24'h0, Q}, 32'h0);
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_done", {31'h0, done}, 32'h0);
      @(negedge clock) reset = 1'b1;

      run_op(3'd0, 4'd0, 8'hB4, 1'b0, 1'b0, "load_b4");
      run_op(3'd1, 4'd3, 8'h00, 1'b0, 1'b0, "ror3");
      run_op(3'd5, 4'd2, 8'h00, 1'b0, 1'b0, "asr2");
      run_op(3'd4, 4'd4, 8'h00, 1'b1, 1'b0, "lsl4");
      run_op(3'd1, 4'd4, 8'h00, 1'b0, 1'b1, "ror4_ign");
      run_op(3'd1, 4'd0, 8'h00, 1'b0, 1'b0, "amt0");
      run_op(3'd7, 4'd5, 8'h11, 1'b1, 1'b0, "nop");
      run_op(3'd0, 4'd0, 8'h3C, 1'b0, 1'b0, "load_3c");
      run_op(3'd2, 4'd8, 8'h00, 1'b0, 1'b0, "rol8");
      run_op(3'd3, 4'd9, 8'h00, 1'b1, 1'b0, "lsr9_s1");
      run_op(3'd3, 4'd15, 8'h00, 1'b0, 1'b0, "lsr15_s0");
      run_op(3'd0, 4'd0, 8'h81, 1'b0, 1'b0, "load_81");
      run_op(3'd5, 4'd3, 8'h00, 1'b0, 1'b0, "asr3");
      run_op(3'd6, 4'd0, 8'hAA, 1'b0, 1'b0, "clear");

      // Back-to-back LOAD/CLEAR/LOAD with start held high.
      bops = '{3'd0, 3'd6, 3'd0};
      bdat = '{8'hA5, 8'h77, 8'h3C};
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         start = 1'b1; op = bops[i]; Data_IN = bdat[i];
         sb_q.push_back(model(bops[i], 4'd0, model_q, model_c, bdat[i], 1'b0));
         @(posedge clock);
         #1;
         exp = sb_q.pop_front();
         model_q = exp[7:0];
         model_c = exp[8];
         check("b2b_q", {24'h0, Q}, {24'h0, exp[7:0]});
         check("b2b_done", {31'h0, done}, 32'h1);
         check("b2b_busy", {31'h0, busy}, 32'h0);
      end
      start = 1'b0;

      // Asynchronous reset mid-operation from Q=FF.
      run_op(3'd0, 4'd0, 8'hFF, 1'b0, 1'b0, "load_ff");
      start_op(3'd1, 4'd10, 8'h00, 1'b0);
      repeat (2) @(posedge clock);
      #3 check("pre_rst_busy", {31'h0, busy}, 32'h1);
      reset = 1'b0;
      #1;
      check("arst_q", {24'h0, Q}, 32'h0);
      check("arst_busy", {31'h0, busy}, 32'h0);
      check("arst_done", {31'h0, done}, 32'h0);
      @(negedge clock) reset = 1'b1;
      model_q = 8'h00;
      model_c = 1'b0;
      done_seen = 0;
      repeat (15) begin
         @(posedge clock);
         #1 if (done) done_seen++;
      end
      check("arst_no_done", done_seen, 0);

      // ROL by 10 from 3C, reset shortly after E5.
      run_op(3'd0, 4'd0, 8'h3C, 1'b0, 1'b0, "load_3c_b");
      start_op(3'd2, 4'd10, 8'h00, 1'b0);
      repeat (5) @(posedge clock);
      #1 reset = 1'b0;
      #1 check("rst_e5_q", {24'h0, Q}, 32'h0);
      @(negedge clock) reset = 1'b1;
      model_q = 8'h00;
      model_c = 1'b0;
      done_seen = 0;
      repeat (15) begin
         @(posedge clock);
         #1 if (done) done_seen++;
      end
      check("rst_e5_no_done", done_seen, 0);
      check("rst_e5_busy", {31'h0, busy}, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
